branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the pipelined RISC-V core: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. Fetch consults it every cycle to choose the next PC. Execute returns each resolved outcome from the branch comparison logic (BEQ/BNE/BLT/BGE). The block trains its table on that outcome and raises a one-cycle mispredict/redirect to the hazard unit.

## Interface
Parameters:
- ENTRIES, 16, table depth; power of two, minimum 2
- XLEN, 32, address width; IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC, word-aligned
- pred_hit  out  1  if_pc matches a valid entry
- pred_taken  out  1  pred_hit & counter[1]
- pred_target  out  XLEN  stored target if pred_taken, else if_pc+4
- ex_valid  in  1  execute stage holds a live (non-bubble) instruction
- ex_branch  in  1  that instruction is a conditional branch
- ex_pc  in  XLEN  its PC
- ex_taken  in  1  resolved outcome
- ex_target  in  XLEN  resolved taken target
- ex_pred_taken  in  1  pred_taken carried down the pipeline with the instruction
- ex_pred_target  in  XLEN  pred_target carried down the pipeline
- mispredict  out  1  flush request
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- stat_branches  out  32  resolved-branch count
- stat_misses  out  32  mispredicted-branch count

## Operation
- Entry fields: valid, tag[TAG_W], target[XLEN], ctr[2]. Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Taken increments and saturates at 11. Not-taken decrements and saturates at 00.
- Lookup (combinational from if_pc): hit = valid & tag match.
- Update, when ex_valid & ex_branch; "hit" means the valid entry at ex_pc matches its tag:
  - hit: step ctr toward the outcome; if ex_taken, overwrite target with ex_target.
  - miss & ex_taken: allocate/replace the entry with tag, target=ex_target, ctr=WT, valid=1.
  - miss & !ex_taken: no write.
- Alias cleanup: ex_valid & !ex_branch & hit at ex_pc clears that entry's valid.
- mispredict = ex_valid & (actual != ex_pred_taken | (actual & ex_target != ex_pred_target)). actual = ex_branch & ex_taken.
- redirect_pc = actual ? ex_target : ex_pc+4. It is don't-care while mispredict=0, but driven deterministically by the same formula.
- stat_branches increments on ex_valid & ex_branch. stat_misses increments on mispredict & ex_branch. Both saturate at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync-safe deassert): all valid=0, all ctr=WNT, targets/tags=0, stats=0.
- Outputs during and immediately after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0 (ex_valid is assumed 0 under reset).
- Lookup latency is 0 cycles (combinational). Table and stat writes take effect at the clk edge after the ex_* inputs are sampled.
- mispredict/redirect_pc are combinational from the ex_* inputs, same cycle. The hazard unit registers them.
- Fetch and update at the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- Reset mid-operation: table contents are lost; no partial write may complete.
- pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC+4 = 0).

## Structure
- Package bp_pkg holds the counter encodings (SNT/WNT/WT/ST), the entry struct typedef, and the index/tag extraction functions.
- Sub-module sat_counter2 is the pure next-state function for (ctr, taken). It is instantiated once, in the update path.
- The table is a register array, not an SRAM macro, because it needs async reset clear and combinational read.

## Test plan
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104. Both stats read 0.
- Resolve taken branch at 0x100 to 0x80 with ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x80, ctr=WT.
- Same branch resolved not-taken twice, ex_pred_* matching current prediction:
  - first: mispredict=1, redirect_pc=0x104, ctr WT->WNT
  - second: mispredict=0, ctr WNT->SNT, stays SNT on a third not-taken
  - then four taken resolutions -> ctr saturates at ST, pred_taken=1
- Aliasing with ENTRIES=16: entry allocated by 0x100, then 0x140 resolved taken to 0x200 -> entry replaced. if_pc=0x100 -> pred_hit=0. if_pc=0x140 -> pred_target=0x200.
- Non-branch at a hit PC with ex_pred_taken=1 -> mispredict=1, redirect_pc=ex_pc+4, entry invalidated, stat_misses unchanged.
- Simultaneous if_pc=ex_pc=0x100 update -> lookup shows old entry that cycle, new entry next cycle. Also assert rst_n mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter states,
// the BTB entry layout and PC-to-index/tag extraction.
package bp_pkg;

    localparam int BP_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Tag is held zero-extended to full width so one entry type serves any table depth.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        ctr_e               ctr;
    } entry_t;

    function automatic logic [BP_XLEN-1:0] pc_index(input logic [BP_XLEN-1:0] pc, input int idx_w);
        logic [BP_XLEN-1:0] mask;
        mask = ~({BP_XLEN{1'b1}} << idx_w);
        return (pc >> 2) & mask;
    endfunction

    function automatic logic [BP_XLEN-1:0] pc_tag(input logic [BP_XLEN-1:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: taken steps toward ST,
// not-taken steps toward SNT.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr
);

    always_comb begin
        // NOTE: default first so every path assigns o_ctr and no latch is inferred.
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr = ctr_e'(i_ctr + 2'd1);
        end else begin
            if (i_ctr != SNT) o_ctr = ctr_e'(i_ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: combinational fetch lookup,
// training from execute, and same-cycle mispredict/redirect generation.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_misses
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    if (XLEN != BP_XLEN || ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || TAG_W < 1) begin : g_bad_param
        $error("branch_predictor: XLEN must equal bp_pkg::BP_XLEN and ENTRIES a power of two >= 2");
    end

    entry_t             r_table [ENTRIES];
    logic [31:0]        r_stat_branches;
    logic [31:0]        r_stat_misses;

    logic [IDX_W-1:0]   w_if_idx;
    logic [BP_XLEN-1:0] w_if_tag;
    entry_t             w_if_entry;
    logic [IDX_W-1:0]   w_ex_idx;
    logic [BP_XLEN-1:0] w_ex_tag;
    entry_t             w_ex_entry;
    logic               w_ex_hit;
    logic               w_actual;
    logic               w_upd_branch;
    ctr_e               w_ctr_next;

    // Fetch-side lookup sees the table as it stood before this cycle's update.
    assign w_if_idx    = IDX_W'(pc_index(if_pc, IDX_W));
    assign w_if_tag    = pc_tag(if_pc, IDX_W);
    assign w_if_entry  = r_table[w_if_idx];
    assign pred_hit    = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign pred_taken  = pred_hit && w_if_entry.ctr[1];
    assign pred_target = pred_taken ? w_if_entry.target : if_pc + XLEN'(4);

    assign w_ex_idx     = IDX_W'(pc_index(ex_pc, IDX_W));
    assign w_ex_tag     = pc_tag(ex_pc, IDX_W);
    assign w_ex_entry   = r_table[w_ex_idx];
    assign w_ex_hit     = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
    assign w_actual     = ex_branch && ex_taken;
    assign w_upd_branch = ex_valid && ex_branch;

    assign mispredict  = ex_valid && ((w_actual != ex_pred_taken) ||
                                      (w_actual && (ex_target != ex_pred_target)));
    assign redirect_pc = w_actual ? ex_target : ex_pc + XLEN'(4);

    sat_counter2 u_ctr (
        .i_ctr   (w_ex_entry.ctr),
        .i_taken (ex_taken),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is plain flops, so it can and must be cleared by reset;
            // a RAM macro could not offer this or the combinational read.
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (w_upd_branch) begin
            if (w_ex_hit) begin
                r_table[w_ex_idx].ctr <= w_ctr_next;
                if (ex_taken) r_table[w_ex_idx].target <= ex_target;
            end else if (ex_taken) begin
                r_table[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: ex_target, ctr: WT};
            end
        end else if (ex_valid && w_ex_hit) begin
            // A non-branch matched an entry: it was aliased, drop it.
            r_table[w_ex_idx].valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= '0;
            r_stat_misses   <= '0;
        end else begin
            if (w_upd_branch && (r_stat_branches != 32'hFFFF_FFFF))
                r_stat_branches <= r_stat_branches + 32'd1;
            if (mispredict && ex_branch && (r_stat_misses != 32'hFFFF_FFFF))
                r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_misses   = r_stat_misses;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor: each vector's expected outputs are
// queued when driven and compared at the following negative edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_misses;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] redirect;
        logic [31:0] branches;
        logic [31:0] misses;
    } exp_t;

    typedef struct {
        logic [31:0] if_pc;
        logic        ev, eb, et, ept;
        logic [31:0] epc, etgt, eptgt;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_misses    (stat_misses)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input logic [31:0] pc, input logic ev, input logic eb, input logic [31:0] epc,
        input logic et, input logic [31:0] etgt, input logic ept, input logic [31:0] eptgt,
        input logic hit, input logic tk, input logic [31:0] tgt,
        input logic mis, input logic [31:0] redir, input logic [31:0] br, input logic [31:0] ms);
        vec_t v;
        v.if_pc = pc;  v.ev = ev;  v.eb = eb;  v.epc = epc;  v.et = et;
        v.etgt = etgt; v.ept = ept; v.eptgt = eptgt;
        v.exp.hit = hit; v.exp.taken = tk; v.exp.target = tgt; v.exp.mis = mis;
        v.exp.redirect = redir; v.exp.branches = br; v.exp.misses = ms;
        return v;
    endfunction

    function automatic vec_t idle(input logic [31:0] pc, input logic hit, input logic tk,
                                  input logic [31:0] tgt, input logic [31:0] br, input logic [31:0] ms);
        return mk(pc, 0, 0, 0, 0, 0, 0, 0, hit, tk, tgt, 0, 32'h4, br, ms);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_pc          = v.if_pc;
        ex_valid       = v.ev;
        ex_branch      = v.eb;
        ex_pc          = v.epc;
        ex_taken       = v.et;
        ex_target      = v.etgt;
        ex_pred_taken  = v.ept;
        ex_pred_target = v.eptgt;
        sb_q.push_back(v.exp);
    endtask

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " pred_hit"},      {31'b0, pred_hit},   {31'b0, e.hit});
            check({tag, " pred_taken"},    {31'b0, pred_taken}, {31'b0, e.taken});
            check({tag, " pred_target"},   pred_target,         e.target);
            check({tag, " mispredict"},    {31'b0, mispredict}, {31'b0, e.mis});
            check({tag, " redirect_pc"},   redirect_pc,         e.redirect);
            check({tag, " stat_branches"}, stat_branches,       e.branches);
            check({tag, " stat_misses"},   stat_misses,         e.misses);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        compare_next(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(idle(32'h100, 0, 0, 32'h104, 0, 0));
        #1;
        compare_next("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Train / saturate at 0x100, alias at 0x140, invalidate, wrap, target mismatch, same-index update.
        vecs.push_back(idle(32'h100, 0, 0, 32'h104, 0, 0));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80,  0, 0));
        vecs.push_back(idle(32'h100, 1, 1, 32'h80, 1, 1));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 1, 32'h80,  1, 32'h104, 1, 1));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 1, 0, 32'h104, 0, 32'h104, 2, 2));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 1, 0, 32'h104, 0, 32'h104, 3, 2));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 1, 0, 32'h104, 1, 32'h80,  4, 2));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 1, 0, 32'h104, 1, 32'h80,  5, 3));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80,  1, 1, 32'h80,  0, 32'h80,  6, 4));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80,  1, 1, 32'h80,  0, 32'h80,  7, 4));
        vecs.push_back(idle(32'h100, 1, 1, 32'h80, 8, 4));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80,  1, 1, 32'h80,  1, 32'h104, 8, 4));
        vecs.push_back(idle(32'h100, 1, 1, 32'h80, 9, 5));
        vecs.push_back(mk(32'h140, 1, 1, 32'h140, 1, 32'h200, 0, 32'h144, 0, 0, 32'h144, 1, 32'h200, 9, 5));
        vecs.push_back(idle(32'h100, 0, 0, 32'h104, 10, 6));
        vecs.push_back(idle(32'h140, 1, 1, 32'h200, 10, 6));
        vecs.push_back(mk(32'h140, 1, 0, 32'h140, 0, 32'h0, 1, 32'h200, 1, 1, 32'h200, 1, 32'h144, 10, 6));
        vecs.push_back(idle(32'h140, 0, 0, 32'h144, 10, 6));
        vecs.push_back(mk(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 10, 6));
        vecs.push_back(mk(32'h200, 0, 1, 32'h0, 1, 32'h300, 1, 32'h300, 0, 0, 32'h204, 0, 32'h300, 11, 6));
        vecs.push_back(mk(32'h108, 1, 1, 32'h108, 1, 32'h400, 1, 32'h500, 0, 0, 32'h10C, 1, 32'h400, 11, 6));
        vecs.push_back(mk(32'h108, 1, 1, 32'h108, 1, 32'h440, 1, 32'h400, 1, 1, 32'h400, 1, 32'h440, 12, 7));
        vecs.push_back(idle(32'h108, 1, 1, 32'h440, 13, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-stream while 0x108 is a predicted-taken hit.
        @(posedge clk);
        #1;
        drive(idle(32'h108, 0, 0, 32'h10C, 0, 0));
        rst_n = 1'b0;
        #1;
        compare_next("mid_reset_now");
        @(posedge clk);
        #1;
        drive(idle(32'h108, 0, 0, 32'h10C, 0, 0));
        @(negedge clk);
        compare_next("mid_reset_held");
        #2;
        rst_n = 1'b1;

        apply(idle(32'h108, 0, 0, 32'h10C, 0, 0), "post_reset_lookup");
        apply(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80, 0, 0), "post_reset_alloc");
        apply(idle(32'h100, 1, 1, 32'h80, 1, 1), "post_reset_hit");

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
